// File: rtl/adc_sample_packer_if.sv
// Sample-in / word-out bundle between the ADC source and the sample packer.
// PACKER_TESTGEN_EN adds the testModeFlag select line.
interface adc_sample_packer_if #(
  parameter int SAMPLE_WIDTH = 10,
  parameter int BUS_WIDTH    = 16
);
  logic                    enable;
  logic                    packedMode;
  logic                    sampleValid;
  logic [SAMPLE_WIDTH-1:0] sampleIn;
`ifdef PACKER_TESTGEN_EN
  logic                    testModeFlag;
`endif
  logic                    wordValid;
  logic [BUS_WIDTH-1:0]    dataOut;
  logic                    flushDone;
  logic                    busy;

  modport master (
`ifdef PACKER_TESTGEN_EN
    output testModeFlag,
`endif
    output enable, packedMode, sampleValid, sampleIn,
    input  wordValid, dataOut, flushDone, busy
  );

  modport slave (
`ifdef PACKER_TESTGEN_EN
    input  testModeFlag,
`endif
    input  enable, packedMode, sampleValid, sampleIn,
    output wordValid, dataOut, flushDone, busy
  );
endinterface

// File: rtl/adc_sample_packer.sv
// Packs SAMPLE_WIDTH-bit ADC samples into BUS_WIDTH-bit words (one per word or dense LSB-first).
// Optional PACKER_TESTGEN_EN replaces sampleIn with an internal ramp counter when latched.
module adc_sample_packer #(
  parameter int SAMPLE_WIDTH = 10,
  parameter int BUS_WIDTH    = 16
) (
  input logic                clock,
  input logic                nReset,
  adc_sample_packer_if.slave bus
);
  localparam int AW = BUS_WIDTH + SAMPLE_WIDTH;
  localparam int FW = $clog2(BUS_WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PACK  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t                  state_r;
  logic [AW-1:0]           acc_r;
  logic [FW-1:0]           fill_r;
  logic                    mode_r;
  logic                    word_valid_r;
  logic [BUS_WIDTH-1:0]    data_r;
  logic                    flush_done_r;
  logic                    busy_r;
`ifdef PACKER_TESTGEN_EN
  logic                    tm_r;
  logic [SAMPLE_WIDTH-1:0] gen_r;
`endif

  logic [SAMPLE_WIDTH-1:0] sample_s;
  logic [AW-1:0]           merged_s;
  logic [FW:0]             sum_s;
  logic                    full_s;

  // Sample source select and packing arithmetic. BUS_WIDTH is a power of two, so the
  // low FW bits of fill+SAMPLE_WIDTH already give the wrapped fill level.
  always_comb begin
    sample_s = bus.sampleIn;
`ifdef PACKER_TESTGEN_EN
    if (tm_r) begin
      sample_s = gen_r;
    end else begin
      sample_s = bus.sampleIn;
    end
`endif
    merged_s = acc_r | (AW'(sample_s) << fill_r);
    sum_s    = {1'b0, fill_r} + (FW+1)'(SAMPLE_WIDTH);
    full_s   = sum_s[FW];
  end

  // Control FSM, accumulator and registered outputs.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      state_r      <= IDLE;
      acc_r        <= '0;
      fill_r       <= '0;
      mode_r       <= 1'b0;
      word_valid_r <= 1'b0;
      data_r       <= '0;
      flush_done_r <= 1'b0;
      busy_r       <= 1'b0;
`ifdef PACKER_TESTGEN_EN
      tm_r         <= 1'b0;
      gen_r        <= '0;
`endif
    end else begin
      word_valid_r <= 1'b0;
      flush_done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.enable) begin
            state_r <= PACK;
            mode_r  <= bus.packedMode;
            busy_r  <= 1'b1;
`ifdef PACKER_TESTGEN_EN
            tm_r    <= bus.testModeFlag;
            gen_r   <= '0;
`endif
          end else begin
            busy_r  <= 1'b0;
          end
        end
        PACK: begin
          if (!bus.enable) begin
            state_r <= FLUSH;
          end else if (bus.sampleValid) begin
            if (mode_r) begin
              fill_r <= sum_s[FW-1:0];
              if (full_s) begin
                data_r       <= merged_s[BUS_WIDTH-1:0];
                word_valid_r <= 1'b1;
                acc_r        <= merged_s >> BUS_WIDTH;
              end else begin
                acc_r        <= merged_s;
              end
            end else begin
              data_r       <= BUS_WIDTH'(sample_s);
              word_valid_r <= 1'b1;
            end
`ifdef PACKER_TESTGEN_EN
            gen_r <= gen_r + SAMPLE_WIDTH'(1);
`endif
          end else begin
            state_r <= PACK;
          end
        end
        FLUSH: begin
          // Bits above fill are always zero, so the partial word is already padded.
          if (mode_r && (fill_r != '0)) begin
            data_r       <= acc_r[BUS_WIDTH-1:0];
            word_valid_r <= 1'b1;
          end
          acc_r        <= '0;
          fill_r       <= '0;
          flush_done_r <= 1'b1;
          busy_r       <= 1'b0;
          state_r      <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.wordValid = word_valid_r;
  assign bus.dataOut   = data_r;
  assign bus.flushDone = flush_done_r;
  assign bus.busy      = busy_r;
endmodule

// File: tb/tb_adc_sample_packer.sv
// Directed self-checking bench for adc_sample_packer at SAMPLE_WIDTH=10, BUS_WIDTH=16.
// Test-generator steps run only when PACKER_TESTGEN_EN is defined.
module tb_adc_sample_packer;
  localparam int SW = 10;
  localparam int BW = 16;

  logic clock;
  logic nReset;
  int   checks;
  int   errors;
  int   words;

  adc_sample_packer_if #(.SAMPLE_WIDTH(SW), .BUS_WIDTH(BW)) bus ();

  adc_sample_packer #(.SAMPLE_WIDTH(SW), .BUS_WIDTH(BW)) dut (
    .clock (clock),
    .nReset(nReset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
    if (bus.wordValid === 1'b1) words++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [SW-1:0] s);
    bus.sampleValid = v;
    bus.sampleIn    = s;
  endtask

  logic [SW-1:0] pk_in  [8];
  logic          pk_wv  [8];
  logic [BW-1:0] pk_out [8];

  initial begin
    checks = 0;
    errors = 0;
    words  = 0;
    nReset = 1'b0;
    bus.enable      = 1'b0;
    bus.packedMode  = 1'b0;
    bus.sampleValid = 1'b0;
    bus.sampleIn    = '0;
`ifdef PACKER_TESTGEN_EN
    bus.testModeFlag = 1'b0;
`endif
    pk_in  = '{10'd0, 10'd1, 10'd2, 10'd3, 10'd4, 10'd5, 10'd6, 10'd7};
    pk_wv  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    pk_out = '{16'h0000, 16'h0400, 16'h0000, 16'hC020, 16'h0400, 16'h0000, 16'h6014, 16'h01C0};

    // Reset state
    #1;
    chk("rst_wordValid", 32'(bus.wordValid), 32'd0);
    chk("rst_dataOut",   32'(bus.dataOut),   32'd0);
    chk("rst_flushDone", 32'(bus.flushDone), 32'd0);
    chk("rst_busy",      32'(bus.busy),      32'd0);
    #1 nReset = 1'b1;

    // UNPACKED 0x3FF, 0x001
    bus.enable = 1'b1;
    tick();
    chk("unp_busy", 32'(bus.busy), 32'd1);
    drive(1'b1, 10'h3FF);
    tick();
    chk("unp_wv0", 32'(bus.wordValid), 32'd1);
    chk("unp_d0",  32'(bus.dataOut),   32'h03FF);
    drive(1'b1, 10'h001);
    tick();
    chk("unp_wv1", 32'(bus.wordValid), 32'd1);
    chk("unp_d1",  32'(bus.dataOut),   32'h0001);
    drive(1'b0, 10'h155);
    tick();
    chk("unp_hold_wv", 32'(bus.wordValid), 32'd0);
    chk("unp_hold_d",  32'(bus.dataOut),   32'h0001);
    bus.enable = 1'b0;
    tick();
    chk("unp_fall_busy", 32'(bus.busy), 32'd1);
    tick();
    chk("unp_flush_wv",   32'(bus.wordValid), 32'd0);
    chk("unp_flush_done", 32'(bus.flushDone), 32'd1);
    chk("unp_flush_busy", 32'(bus.busy),      32'd0);

    // PACKED samples 0..7 -> five words, fill returns to 0
    bus.packedMode = 1'b1;
    bus.enable     = 1'b1;
    tick();
    words = 0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, pk_in[i]);
      tick();
      chk($sformatf("pk_wv%0d", i), 32'(bus.wordValid), 32'(pk_wv[i]));
      if (pk_wv[i]) chk($sformatf("pk_d%0d", i), 32'(bus.dataOut), 32'(pk_out[i]));
    end
    drive(1'b0, 10'h000);
    bus.enable = 1'b0;
    tick();
    tick();
    chk("pk_noflush_wv",  32'(bus.wordValid), 32'd0);
    chk("pk_noflush_fd",  32'(bus.flushDone), 32'd1);
    chk("pk_words",       32'(words),         32'd5);

    // PACKED three samples, then enable falls with a valid sample that must be dropped
    words = 0;
    bus.enable = 1'b1;
    tick();
    drive(1'b1, 10'h3FF);
    tick();
    chk("pf_wv0", 32'(bus.wordValid), 32'd0);
    tick();
    chk("pf_wv1", 32'(bus.wordValid), 32'd1);
    chk("pf_d1",  32'(bus.dataOut),   32'hFFFF);
    tick();
    chk("pf_wv2", 32'(bus.wordValid), 32'd0);
    bus.enable = 1'b0;
    drive(1'b1, 10'h155);
    tick();
    chk("pf_drop_wv", 32'(bus.wordValid), 32'd0);
    chk("pf_drop_busy", 32'(bus.busy),    32'd1);
    drive(1'b0, 10'h000);
    tick();
    chk("pf_flush_wv",   32'(bus.wordValid), 32'd1);
    chk("pf_flush_d",    32'(bus.dataOut),   32'h3FFF);
    chk("pf_flush_done", 32'(bus.flushDone), 32'd1);
    chk("pf_flush_busy", 32'(bus.busy),      32'd0);
    tick();
    chk("pf_done_once", 32'(bus.flushDone), 32'd0);
    chk("pf_words",     32'(words),         32'd2);

    // Reset mid-word discards partial data and restarts at fill 0
    bus.enable = 1'b1;
    tick();
    drive(1'b1, 10'h2AA);
    tick();
    drive(1'b0, 10'h000);
    nReset = 1'b0;
    #1;
    chk("mr_wv",   32'(bus.wordValid), 32'd0);
    chk("mr_d",    32'(bus.dataOut),   32'd0);
    chk("mr_fd",   32'(bus.flushDone), 32'd0);
    chk("mr_busy", 32'(bus.busy),      32'd0);
    tick();
    chk("mr_hold_wv", 32'(bus.wordValid), 32'd0);
    nReset = 1'b1;
    tick();
    chk("mr_restart_busy", 32'(bus.busy), 32'd1);
    drive(1'b1, 10'h001);
    tick();
    chk("mr_s0_wv", 32'(bus.wordValid), 32'd0);
    tick();
    chk("mr_s1_wv", 32'(bus.wordValid), 32'd1);
    chk("mr_s1_d",  32'(bus.dataOut),   32'h0401);
    drive(1'b0, 10'h000);
    bus.enable = 1'b0;
    tick();
    tick();

`ifdef PACKER_TESTGEN_EN
    // Internal ramp replaces sampleIn, wraps after 0x3FF
    bus.packedMode   = 1'b0;
    bus.testModeFlag = 1'b1;
    bus.enable       = 1'b1;
    tick();
    drive(1'b1, 10'h155);
    for (int i = 0; i < 1025; i++) begin
      tick();
      chk($sformatf("tg_d%0d", i), 32'(bus.dataOut), 32'(i % 1024));
    end
    drive(1'b0, 10'h000);
    bus.enable       = 1'b0;
    bus.testModeFlag = 1'b0;
    tick();
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
